// File: rtl/uart_io_if.sv
// CPU-side byte I/O bus of the UART peripheral: transmit request/busy and
// receive data/ready/acknowledge plus the one-cycle error pulses.
interface uart_io_if;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       irr;
    logic       ack;
    logic       rx_overrun;
    logic       rx_frame_err;

    modport master (
        output tx_req, tx_data, ack,
        input  tx_busy, rx_data, irr, rx_overrun, rx_frame_err
    );

    modport slave (
        input  tx_req, tx_data, ack,
        output tx_busy, rx_data, irr, rx_overrun, rx_frame_err
    );
endinterface

// File: rtl/uart_io.sv
// 8N1 UART (LSB first, idle high) with independent TX and RX engines.
// The CPU side is edge-triggered: rising tx_req starts a send, rising ack clears irr.
module uart_io #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     uart_rx,
    output logic     uart_tx,
    uart_io_if.slave cpu
);
    localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_e;

    // ---------------- transmitter ----------------
    tx_state_e       tx_state_q, tx_state_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            uart_tx_q, uart_tx_d;
    logic            tx_busy_q, tx_busy_d;
    logic            tx_req_q, tx_req_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        uart_tx_d  = uart_tx_q;
        tx_busy_d  = tx_busy_q;
        tx_req_d   = cpu.tx_req;
        unique case (tx_state_q)
            TxIdle: begin
                // Edges arriving outside IDLE are dropped, not queued.
                if (cpu.tx_req && !tx_req_q) begin
                    tx_shift_d = cpu.tx_data;
                    uart_tx_d  = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_cnt_d   = '0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    uart_tx_d  = tx_shift_q[0];
                    tx_state_d = TxData;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TxData: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        uart_tx_d  = 1'b1;
                        tx_state_d = TxStop;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        uart_tx_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TxStop: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d   = '0;
                    tx_busy_d  = 1'b0;
                    tx_state_d = TxIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            uart_tx_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_req_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            uart_tx_q  <= uart_tx_d;
            tx_busy_q  <= tx_busy_d;
            tx_req_q   <= tx_req_d;
        end
    end

    // ---------------- receiver ----------------
    logic            rx_sync1_q, rx_sync2_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            irr_q, irr_d;
    logic            ack_q, ack_d;
    logic            rx_overrun_q, rx_overrun_d;
    logic            rx_frame_err_q, rx_frame_err_d;
    logic            rx_line;
    logic            commit;

    assign rx_line = rx_sync2_q;

    always_comb begin
        rx_state_d     = rx_state_q;
        rx_cnt_d       = rx_cnt_q;
        rx_bit_d       = rx_bit_q;
        rx_shift_d     = rx_shift_q;
        rx_frame_err_d = 1'b0;
        commit         = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (!rx_line) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                // Re-check the start bit at its centre to reject short glitches.
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_line ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_line, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d = '0;
                    if (rx_line) begin
                        commit     = 1'b1;
                        rx_state_d = RxIdle;
                    end else begin
                        rx_frame_err_d = 1'b1;
                        rx_state_d     = RxWaitHigh;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxWaitHigh: begin
                if (rx_line) begin
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // A commit outranks a coincident ack edge; overrun looks at irr before the ack.
    always_comb begin
        ack_d        = cpu.ack;
        rx_data_d    = rx_data_q;
        irr_d        = irr_q;
        rx_overrun_d = 1'b0;
        if (commit) begin
            rx_data_d    = rx_shift_q;
            irr_d        = 1'b1;
            rx_overrun_d = irr_q;
        end else if (cpu.ack && !ack_q) begin
            irr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync1_q     <= 1'b1;
            rx_sync2_q     <= 1'b1;
            rx_state_q     <= RxIdle;
            rx_cnt_q       <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            irr_q          <= 1'b0;
            ack_q          <= 1'b0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            rx_sync1_q     <= uart_rx;
            rx_sync2_q     <= rx_sync1_q;
            rx_state_q     <= rx_state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_bit_q       <= rx_bit_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            irr_q          <= irr_d;
            ack_q          <= ack_d;
            rx_overrun_q   <= rx_overrun_d;
            rx_frame_err_q <= rx_frame_err_d;
        end
    end

    assign uart_tx          = uart_tx_q;
    assign cpu.tx_busy      = tx_busy_q;
    assign cpu.rx_data      = rx_data_q;
    assign cpu.irr          = irr_q;
    assign cpu.rx_overrun   = rx_overrun_q;
    assign cpu.rx_frame_err = rx_frame_err_q;
endmodule

// File: tb/tb_uart_io.sv
// Bench for uart_io at 8 clocks per bit: vector tables, hand-built corner
// sequences and randomized traffic against a frame-level model.
module tb_uart_io;
    localparam int Cpb      = 8;
    localparam int FrameLen = 10 * Cpb;
    localparam int Tail     = 12;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic rx_drv   = 1'b1;
    logic loopback = 1'b0;
    logic uart_tx;
    wire  uart_rx;

    uart_io_if bus ();

    assign uart_rx = loopback ? uart_tx : rx_drv;

    uart_io #(.CLKS_PER_BIT(Cpb)) dut (
        .clk     (clk),
        .reset   (reset),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .cpu     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int ovr_cnt  = 0;
    int ferr_cnt = 0;

    always @(negedge clk) begin
        if (bus.rx_overrun) ovr_cnt++;
        if (bus.rx_frame_err) ferr_cnt++;
    end

    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;
    } tx_vec_t;

    typedef struct {
        logic       pre_ack;
        logic [7:0] d;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_irr;
        int         exp_ovr;
        int         exp_ferr;
    } rx_vec_t;

    tx_vec_t tx_tab[6];
    rx_vec_t rx_tab[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Line order on the wire: start 0, data LSB first, stop 1.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        logic [9:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i + 1] = d[i];
        f[9] = 1'b1;
        return f;
    endfunction

    // Raise tx_req at the current negedge and watch the next FrameLen cycles.
    task automatic tx_frame(input logic [7:0] d, input int inj_at, input logic [7:0] inj_d,
                            output logic [9:0] mid, output int changes, output int busy_n);
        logic prev;
        bus.tx_data = d;
        bus.tx_req  = 1'b1;
        mid     = '1;
        changes = 0;
        busy_n  = 0;
        prev    = 1'b1;
        for (int k = 0; k < FrameLen; k++) begin
            @(negedge clk);
            if (k > 0 && (k % Cpb) != 0 && uart_tx !== prev) changes++;
            prev = uart_tx;
            if ((k % Cpb) == Cpb / 2) mid[k / Cpb] = uart_tx;
            if (bus.tx_busy) busy_n++;
            if (inj_at >= 0 && k == 2) bus.tx_req = 1'b0;
            if (k == inj_at) begin
                bus.tx_data = inj_d;
                bus.tx_req  = 1'b1;
            end
        end
    endtask

    task automatic tx_check(input string name, input logic [7:0] d, input logic [9:0] exp_frame,
                            input int inj_at, input logic [7:0] inj_d);
        logic [9:0] mid;
        int         chg;
        int         bsy;
        tx_frame(d, inj_at, inj_d, mid, chg, bsy);
        chk({name, " frame"}, 32'(mid), 32'(exp_frame));
        chk({name, " mid-bit edges"}, chg, 0);
        chk({name, " busy cycles"}, bsy, FrameLen);
    endtask

    // Drive one frame onto rx_drv; optional ack pulse, reset pulse and extended break.
    task automatic rx_frame(input logic [7:0] d, input logic stop, input int ack_at,
                            input int rst_at, input int brk);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int k = 0; k < FrameLen + brk + Tail; k++) begin
            if (rst_at >= 0 && k >= rst_at) rx_drv = 1'b1;
            else if (k < FrameLen) rx_drv = bits[k / Cpb];
            else if (k < FrameLen + brk) rx_drv = 1'b0;
            else rx_drv = 1'b1;
            if (ack_at >= 0) bus.ack = (k == ack_at);
            if (rst_at >= 0) reset = (k == rst_at);
            @(negedge clk);
        end
    endtask

    task automatic ack_pulse();
        bus.ack = 1'b1;
        tick(1);
        bus.ack = 1'b0;
        tick(1);
    endtask

    initial begin
        int         o0;
        int         f0;
        int         busy_extra;
        int         n_early;
        int         n_both;
        int         n_late;
        int         n_bad;
        int         viol;
        int         phase;
        int         last_phase;
        logic       irr_m;
        logic [7:0] data_m;
        logic [7:0] d;
        logic       pre;
        logic       stop;

        bus.tx_req  = 1'b0;
        bus.tx_data = 8'h00;
        bus.ack     = 1'b0;

        tx_tab[0] = '{8'hA5, 10'b1_10100101_0};
        tx_tab[1] = '{8'h3C, 10'b1_00111100_0};
        tx_tab[2] = '{8'h00, 10'b1_00000000_0};
        tx_tab[3] = '{8'hFF, 10'b1_11111111_0};
        tx_tab[4] = '{8'h01, 10'b1_00000001_0};
        tx_tab[5] = '{8'h80, 10'b1_10000000_0};

        rx_tab[0] = '{1'b0, 8'h11, 1'b1, 8'h11, 1'b1, 0, 0};
        rx_tab[1] = '{1'b0, 8'h22, 1'b1, 8'h22, 1'b1, 1, 0};
        rx_tab[2] = '{1'b1, 8'h81, 1'b0, 8'h22, 1'b0, 0, 1};
        rx_tab[3] = '{1'b0, 8'hC3, 1'b1, 8'hC3, 1'b1, 0, 0};
        rx_tab[4] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1, 0};
        rx_tab[5] = '{1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 0};
        rx_tab[6] = '{1'b1, 8'h7E, 1'b0, 8'hFF, 1'b0, 0, 1};

        tick(3);
        reset = 1'b0;
        tick(2);
        chk("reset uart_tx", 32'(uart_tx), 1);
        chk("reset tx_busy", 32'(bus.tx_busy), 0);
        chk("reset rx_data", 32'(bus.rx_data), 0);
        chk("reset irr", 32'(bus.irr), 0);
        chk("reset rx_overrun", 32'(bus.rx_overrun), 0);
        chk("reset rx_frame_err", 32'(bus.rx_frame_err), 0);

        // Table: each frame starts in the first idle cycle after the previous one.
        for (int i = 0; i < 6; i++) begin
            tx_check($sformatf("tx_tab[%0d]", i), tx_tab[i].d, tx_tab[i].frame, -1, 8'h00);
            bus.tx_req = 1'b0;
            tick(1);
            chk($sformatf("tx_tab[%0d] idle busy", i), 32'(bus.tx_busy), 0);
            chk($sformatf("tx_tab[%0d] idle line", i), 32'(uart_tx), 1);
        end

        // Holding tx_req high sends exactly one byte.
        tx_check("hold", 8'hA5, 10'b1_10100101_0, -1, 8'h00);
        busy_extra = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (bus.tx_busy || !uart_tx) busy_extra++;
        end
        chk("hold no resend", busy_extra, 0);
        bus.tx_req = 1'b0;
        tick(1);

        // An edge mid-frame is dropped; a fresh edge afterwards is honoured.
        tx_check("busy drop", 8'hA5, 10'b1_10100101_0, 20, 8'h3C);
        tick(4);
        chk("busy drop not queued", 32'(bus.tx_busy), 0);
        bus.tx_req = 1'b0;
        tick(1);
        tx_check("after drop", 8'h3C, 10'b1_00111100_0, -1, 8'h00);
        bus.tx_req = 1'b0;
        tick(1);

        loopback = 1'b1;
        tx_check("loopback tx", 8'h5A, 10'b1_01011010_0, -1, 8'h00);
        bus.tx_req = 1'b0;
        tick(6);
        chk("loopback rx_data", 32'(bus.rx_data), 32'h5A);
        chk("loopback irr", 32'(bus.irr), 1);
        bus.ack = 1'b1;
        tick(1);
        chk("loopback ack clears irr", 32'(bus.irr), 0);
        bus.ack = 1'b0;
        loopback = 1'b0;
        tick(2);

        for (int i = 0; i < 7; i++) begin
            if (rx_tab[i].pre_ack) ack_pulse();
            o0 = ovr_cnt;
            f0 = ferr_cnt;
            rx_frame(rx_tab[i].d, rx_tab[i].stop, -1, -1, 0);
            chk($sformatf("rx_tab[%0d] rx_data", i), 32'(bus.rx_data), 32'(rx_tab[i].exp_data));
            chk($sformatf("rx_tab[%0d] irr", i), 32'(bus.irr), 32'(rx_tab[i].exp_irr));
            chk($sformatf("rx_tab[%0d] overrun", i), ovr_cnt - o0, rx_tab[i].exp_ovr);
            chk($sformatf("rx_tab[%0d] frame_err", i), ferr_cnt - f0, rx_tab[i].exp_ferr);
        end

        // Short low glitch is not a start bit.
        o0 = ovr_cnt;
        f0 = ferr_cnt;
        rx_drv = 1'b0;
        tick(3);
        rx_drv = 1'b1;
        tick(20);
        chk("glitch frame_err", ferr_cnt - f0, 0);
        chk("glitch overrun", ovr_cnt - o0, 0);
        chk("glitch irr", 32'(bus.irr), 0);
        chk("glitch rx_data", 32'(bus.rx_data), 32'hFF);

        // Long break after a bad stop bit must yield a single error.
        f0 = ferr_cnt;
        rx_frame(8'h81, 1'b0, -1, -1, 12 * Cpb);
        chk("break frame_err once", ferr_cnt - f0, 1);
        chk("break rx_data kept", 32'(bus.rx_data), 32'hFF);
        chk("break irr kept", 32'(bus.irr), 0);
        rx_frame(8'h3C, 1'b1, -1, -1, 0);
        chk("after break rx_data", 32'(bus.rx_data), 32'h3C);
        chk("after break irr", 32'(bus.irr), 1);

        // Level-held ack clears only once.
        bus.ack = 1'b1;
        tick(2);
        chk("held ack clears", 32'(bus.irr), 0);
        rx_frame(8'hA7, 1'b1, -1, -1, 0);
        chk("held ack new byte irr", 32'(bus.irr), 1);
        chk("held ack new byte data", 32'(bus.rx_data), 32'hA7);
        bus.ack = 1'b0;
        tick(1);

        // Sweep an ack edge across the commit: before, coincident, after.
        n_early    = 0;
        n_both     = 0;
        n_late     = 0;
        n_bad      = 0;
        viol       = 0;
        last_phase = 0;
        for (int off = 70; off <= 86; off++) begin
            rx_frame(8'h55, 1'b1, -1, -1, 0);
            d  = 8'(off);
            o0 = ovr_cnt;
            rx_frame(d, 1'b1, off, -1, 0);
            chk($sformatf("sweep %0d rx_data", off), 32'(bus.rx_data), 32'(d));
            phase = -1;
            if (bus.irr && (ovr_cnt - o0) == 0) begin n_early++; phase = 0; end
            else if (bus.irr && (ovr_cnt - o0) == 1) begin n_both++; phase = 1; end
            else if (!bus.irr && (ovr_cnt - o0) == 1) begin n_late++; phase = 2; end
            else n_bad++;
            if (phase >= 0) begin
                if (phase < last_phase) viol++;
                last_phase = phase;
            end
        end
        chk("sweep coincident commit wins", n_both, 1);
        chk("sweep illegal outcomes", n_bad, 0);
        chk("sweep ordering", viol, 0);
        chk("sweep early seen", 32'(n_early > 0), 1);
        chk("sweep late seen", 32'(n_late > 0), 1);

        // Reset during TX data bit 4.
        bus.tx_data = 8'hEF;
        bus.tx_req  = 1'b1;
        tick(1);
        tick(5 * Cpb + 3);
        chk("tx reset pre line", 32'(uart_tx), 0);
        reset = 1'b1;
        tick(1);
        chk("tx reset line", 32'(uart_tx), 1);
        chk("tx reset busy", 32'(bus.tx_busy), 0);
        reset = 1'b0;
        bus.tx_req = 1'b0;
        tick(2);

        // Reset during RX data bits.
        rx_frame(8'h99, 1'b1, -1, -1, 0);
        chk("rx pre-reset irr", 32'(bus.irr), 1);
        rx_frame(8'h44, 1'b1, -1, 30, 0);
        chk("rx reset irr", 32'(bus.irr), 0);
        chk("rx reset rx_data", 32'(bus.rx_data), 0);
        o0 = ovr_cnt;
        rx_frame(8'hC3, 1'b1, -1, -1, 0);
        chk("rx after reset data", 32'(bus.rx_data), 32'hC3);
        chk("rx after reset irr", 32'(bus.irr), 1);
        chk("rx after reset overrun", ovr_cnt - o0, 0);

        // Randomized loopback traffic against the frame model.
        irr_m    = 1'b1;
        data_m   = 8'hC3;
        loopback = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d   = 8'($urandom);
            pre = 1'($urandom_range(0, 1));
            if (pre) begin
                ack_pulse();
                irr_m = 1'b0;
            end
            o0 = ovr_cnt;
            tx_check($sformatf("rand lb %0d", i), d, model_frame(d), -1, 8'h00);
            bus.tx_req = 1'b0;
            tick(6);
            chk($sformatf("rand lb %0d overrun", i), ovr_cnt - o0, 32'(irr_m));
            irr_m  = 1'b1;
            data_m = d;
            chk($sformatf("rand lb %0d rx_data", i), 32'(bus.rx_data), 32'(data_m));
            chk($sformatf("rand lb %0d irr", i), 32'(bus.irr), 32'(irr_m));
        end
        loopback = 1'b0;
        tick(2);

        // Randomized direct RX frames, some with a bad stop bit.
        for (int i = 0; i < 12; i++) begin
            d    = 8'($urandom);
            pre  = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) != 0);
            if (pre) begin
                ack_pulse();
                irr_m = 1'b0;
            end
            o0 = ovr_cnt;
            f0 = ferr_cnt;
            rx_frame(d, stop, -1, -1, 0);
            if (stop) begin
                chk($sformatf("rand rx %0d overrun", i), ovr_cnt - o0, 32'(irr_m));
                irr_m  = 1'b1;
                data_m = d;
            end else begin
                chk($sformatf("rand rx %0d overrun", i), ovr_cnt - o0, 0);
            end
            chk($sformatf("rand rx %0d frame_err", i), ferr_cnt - f0, 32'(!stop));
            chk($sformatf("rand rx %0d rx_data", i), 32'(bus.rx_data), 32'(data_m));
            chk($sformatf("rand rx %0d irr", i), 32'(bus.irr), 32'(irr_m));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_io.md
Name: uart_io

Overview:
- Serial peripheral at the far end of the CPU's byte I/O interface.
- Serialises bytes the CPU requests over tx_req/tx_data, and reports progress on tx_busy.
- Deserialises incoming UART frames into rx_data and raises irr until the CPU pulses ack.
- Format is 8N1, LSB first, line idle high. Sits between the CPU core and the board UART pins.

Parameters:
CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200); legal range is 4 or more.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
uart_rx  input  1  asynchronous serial input pin
uart_tx  output  1  serial output pin
tx_req  input  1  CPU transmit request; the rising edge is significant
tx_data  input  8  byte to send; sampled on the accepted tx_req edge
tx_busy  output  1  transmitter occupied
rx_data  output  8  last received byte
irr  output  1  receive-ready flag to CPU
ack  input  1  CPU acknowledge; the rising edge clears irr
rx_overrun  output  1  one-cycle pulse: a byte completed while irr was already 1
rx_frame_err  output  1  one-cycle pulse: stop bit sampled low

Behaviour:
Reset values:
- uart_tx=1, tx_busy=0, rx_data=0, irr=0, rx_overrun=0, rx_frame_err=0.
- Both FSMs return to IDLE; bit counters and sample counters are 0.
- Edge registers: tx_req_d=0, ack_d=0.
- Synchroniser flops are preset to 1.
- Reset mid-frame aborts immediately; uart_tx is 1 on the next cycle and no partial byte is committed.

TX FSM (IDLE, START, DATA, STOP):
- Accept: in IDLE, with tx_req=1 and tx_req_d=0, latch tx_data. On the next edge: uart_tx=0, tx_busy=1, state START.
- A rising edge while not IDLE is ignored and not queued. Holding tx_req high sends exactly one byte.
- START lasts CLKS_PER_BIT cycles. DATA outputs bits 0..7, CLKS_PER_BIT cycles each. STOP drives 1 for CLKS_PER_BIT cycles.
- Total frame is 10*CLKS_PER_BIT cycles. tx_busy is 1 for exactly those cycles and falls in the same cycle the FSM returns to IDLE.
- Back-to-back sends: a new edge is accepted in the first IDLE cycle.

RX path:
- uart_rx passes through a 2-flop synchroniser; all RX decisions use its output.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: synced line =0 -> START, counter cleared.
- START: after CLKS_PER_BIT/2 cycles (integer divide), sample. If 0 -> DATA; if 1, treat as a glitch -> IDLE with no flags.
- DATA: sample every CLKS_PER_BIT cycles (mid-bit) and shift in LSB first; after 8 samples -> STOP.
- STOP: after CLKS_PER_BIT cycles, sample.
  - If 1: rx_data<=byte and irr<=1 on the next edge, then -> IDLE.
  - If 0: pulse rx_frame_err, leave rx_data and irr unchanged, -> WAIT_HIGH.
- WAIT_HIGH: stay until synced line =1, then -> IDLE. A held break generates one error only.

irr/ack rules:
- irr clears on the cycle after ack=1 and ack_d=0. Level-held ack does not clear later bytes.
- Overrun: if a byte commits while irr=1, rx_data is overwritten, irr stays 1, and rx_overrun pulses.
- Simultaneous commit and ack edge: the commit wins, so irr=1 with the new byte. rx_overrun pulses only if irr was 1 before the ack edge.

Other rules:
- TX and RX are fully independent and may run concurrently.
- Input latency from the uart_rx pin to any RX decision is 2 cycles.

Test Plan:
(All scenarios use CLKS_PER_BIT=8.)
- TX byte: tx_data=0xA5, tx_req 0->1 -> uart_tx=0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles; tx_busy=1 for exactly 80 cycles; holding tx_req high afterwards sends nothing more.
- Busy drop: second tx_req edge with tx_data=0x3C at cycle 20 of a frame -> ignored; only 0xA5 is sent; a new edge after tx_busy falls sends 0x3C.
- Loopback: uart_tx tied to uart_rx, send 0x5A -> irr=1 and rx_data=0x5A shortly after the stop bit; ack 0->1 -> irr=0 the next cycle.
- Overrun: receive 0x11 and then 0x22 with no ack -> rx_data=0x22, irr=1, one rx_overrun pulse; same-cycle ack edge plus commit -> irr stays 1.
- Framing/glitch: a 3-cycle low pulse on uart_rx -> no flags. A frame for 0x81 with the stop bit low -> rx_frame_err pulses once, rx_data is unchanged, and reception waits for the line to go high.
- Reset mid-frame: reset during TX bit 4 -> uart_tx=1 and tx_busy=0 the next cycle. Reset during RX DATA -> irr=0, rx_data=0, and the next clean frame 0xC3 is received correctly.
